// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Assembles little-endian words from a byte stream and verifies an XOR checksum.
module imem_loader #(
   parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
   parameter int          MAX_WORDS = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_PAYLOAD,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [31:0] MaxW = 32'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] words_q, words_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  csum_q, csum_d;
   logic        take;
   logic [15:0] hdr_n;

   // Handshake and status outputs decode directly from the state register
   always_comb begin
      rx_ready = 1'b0;
      unique case (state_q)
         S_HDR0, S_HDR1, S_PAYLOAD, S_CSUM: rx_ready = 1'b1;
         default:                           rx_ready = 1'b0;
      endcase
   end

   assign take         = rx_valid & rx_ready;
   assign hdr_n        = {rx_data, count_q[7:0]};
   assign mem_we       = (state_q == S_WRITE);
   assign mem_adr      = BASE_ADR + {14'd0, words_q, 2'b00};
   assign mem_wdata    = word_q;
   assign cpu_hold     = (state_q != S_DONE);
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign words_loaded = words_q;

   // Next-state logic: header parse, word assembly, write and checksum
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      words_d = words_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      csum_d  = csum_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR0;
               count_d = '0;
               words_d = '0;
               bcnt_d  = '0;
               csum_d  = '0;
            end
         end
         S_HDR0: begin
            if (take) begin
               count_d[7:0] = rx_data;
               csum_d       = csum_q ^ rx_data;
               state_d      = S_HDR1;
            end
         end
         S_HDR1: begin
            if (take) begin
               count_d[15:8] = rx_data;
               csum_d        = csum_q ^ rx_data;
               bcnt_d        = '0;
               if ({16'd0, hdr_n} > MaxW) state_d = S_ERR;
               else if (hdr_n == 16'd0)   state_d = S_CSUM;
               else                       state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (take) begin
               word_d = {rx_data, word_q[31:8]};
               csum_d = csum_q ^ rx_data;
               bcnt_d = 2'(bcnt_q + 2'd1);
               if (bcnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            words_d = words_q + 16'd1;
            if ((words_q + 16'd1) < count_q) state_d = S_PAYLOAD;
            else                             state_d = S_CSUM;
         end
         S_CSUM: begin
            if (take) begin
               if (rx_data == csum_q) state_d = S_DONE;
               else                   state_d = S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         words_q <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         words_q <= words_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Vector table of whole streams plus a reset-abort sequence.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   imem_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .mem_we       (mem_we),
      .mem_adr      (mem_adr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   typedef struct {
      logic [127:0] s;
      int           len;
      bit           gaps;
      bit           d;
      bit           e;
      int           nw;
      int           nwr;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   vec_t vt[6];

   int errors = 0;
   int checks = 0;
   int rdy_in_wr = 0;
   logic [31:0] wr_adr[$];
   logic [31:0] wr_dat[$];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_adr.push_back(mem_adr);
         wr_dat.push_back(mem_wdata);
         if (rx_ready !== 1'b0) rdy_in_wr++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [127:0] s, input int len,
                       input bit gaps);
      int n;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               rx_valid = 1'b0;
               @(negedge clk);
            end
         end
         rx_valid = 1'b1;
         rx_data  = s[127-8*i -: 8];
         n = 0;
         while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0d got no rx_ready want 1", i);
            rx_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      wr_adr.delete();
      wr_dat.delete();
      pulse_start();
      send(v.s, v.len, v.gaps);
      @(negedge clk);
      chk($sformatf("v%0d_done", k), 32'(done), 32'(v.d));
      chk($sformatf("v%0d_error", k), 32'(error), 32'(v.e));
      chk($sformatf("v%0d_hold", k), 32'(cpu_hold), 32'(!v.d));
      chk($sformatf("v%0d_rdy", k), 32'(rx_ready), 32'd0);
      chk($sformatf("v%0d_words", k), 32'(words_loaded), 32'(v.nw));
      chk($sformatf("v%0d_nwr", k), 32'(wr_adr.size()), 32'(v.nwr));
      if (v.nwr > 0 && wr_adr.size() > 0) begin
         chk($sformatf("v%0d_adr0", k), wr_adr[0], 32'h0);
         chk($sformatf("v%0d_dat0", k), wr_dat[0], v.w0);
      end
      if (v.nwr > 1 && wr_adr.size() > 1) begin
         chk($sformatf("v%0d_adr1", k), wr_adr[1], 32'h4);
         chk($sformatf("v%0d_dat1", k), wr_dat[1], v.w1);
      end
   endtask

   initial begin
      vt[0] = '{{88'h0200205000001400012443, 40'h0}, 11, 1'b0,
                1'b1, 1'b0, 2, 2, 32'h0000_5020, 32'h2401_0014};
      vt[1] = '{{88'h0200205000001400012444, 40'h0}, 11, 1'b0,
                1'b0, 1'b1, 2, 2, 32'h0000_5020, 32'h2401_0014};
      vt[2] = '{128'h0, 3, 1'b0,
                1'b1, 1'b0, 0, 0, 32'h0, 32'h0};
      vt[3] = '{{88'h0200205000001400012443, 40'h0}, 11, 1'b1,
                1'b1, 1'b0, 2, 2, 32'h0000_5020, 32'h2401_0014};
      vt[4] = '{{16'hFFFF, 112'h0}, 2, 1'b0,
                1'b0, 1'b1, 0, 0, 32'h0, 32'h0};
      vt[5] = '{{56'h0100AABBCCDD01, 72'h0}, 7, 1'b0,
                1'b1, 1'b0, 1, 1, 32'hDDCC_BBAA, 32'h0};

      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_rdy", 32'(rx_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(vt[k], k);

      // Reset after two payload bytes: abort, then a clean reload
      wr_adr.delete();
      wr_dat.delete();
      pulse_start();
      send({32'h02002050, 96'h0}, 4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
      chk("mid_rst_rdy", 32'(rx_ready), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_words", 32'(words_loaded), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h00;
      repeat (10) @(negedge clk);
      rx_valid = 1'b0;
      chk("mid_rst_nowr", 32'(wr_adr.size()), 32'd0);
      chk("mid_rst_idle_rdy", 32'(rx_ready), 32'd0);
      run_vec(vt[0], 6);

      chk("rdy_during_write", 32'(rdy_in_wr), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time loader that fills the byte-addressed, little-endian instruction memory from an 8-bit byte stream before the single-cycle CPU starts. It is the write side of the instruction memory: it assembles 32-bit words from incoming bytes and issues one-cycle word writes to the memory's write port. It holds the CPU stalled until a complete, checksum-verified image has been written.

Parameters:
BASE_ADR, 32'h0000_0000, byte address of the first word written (word-aligned).
MAX_WORDS, 16384, largest accepted word count (64 KB / 4).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a load.
rx_data  input  8  incoming stream byte.
rx_valid  input  1  rx_data valid.
rx_ready  output  1  loader accepts the byte this cycle.
mem_we  output  1  instruction-memory word write enable.
mem_adr  output  32  byte address of the write.
mem_wdata  output  32  write word; bits 7:0 go to mem[adr], bits 31:24 to mem[adr+3].
cpu_hold  output  1  stall the CPU (PC and register-file writes).
done  output  1  image loaded and verified.
error  output  1  load failed (bad checksum or oversize count).
words_loaded  output  16  words written during the current load.

Behaviour:
- Byte transfer: a byte is consumed on a rising clk edge where rx_valid=1 and rx_ready=1. No other edge consumes it. rx_data is ignored when rx_valid=0.
- Stream format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then 4*N payload bytes, then one CSUM byte.
- Payload bytes are taken least-significant first, so byte k of a word lands in mem_wdata[8k+7:8k].
- CSUM must equal the XOR of every preceding byte, header included.
- States:
  - IDLE: wait for start.
  - HDR0, HDR1: receive the two count bytes.
  - PAYLOAD: receive the 4 bytes of the current word.
  - WRITE: perform the word write.
  - CSUM: receive and check the checksum byte.
  - DONE, ERR: terminal until start or reset.
- rx_ready=1 only in HDR0, HDR1, PAYLOAD and CSUM. It is 0 in all other states.
- Transitions:
  - IDLE --start--> HDR0.
  - HDR0 --byte--> HDR1.
  - HDR1 --byte--> ERR if N > MAX_WORDS; else CSUM if N = 0; else PAYLOAD.
  - PAYLOAD --4th byte--> WRITE.
  - WRITE --1 cycle--> PAYLOAD if words written < N, else CSUM.
  - CSUM --byte--> DONE on match, else ERR.
- WRITE cycle:
  - mem_we=1 for exactly one cycle.
  - mem_adr = BASE_ADR + 4*index, 32-bit modulo arithmetic.
  - mem_wdata = the assembled word.
  - index and words_loaded increment at the end of the cycle.
  - mem_adr and mem_wdata are don't-care when mem_we=0.
- Outputs are registered. Write latency is one cycle after the 4th byte of a word is consumed.
- cpu_hold=1 in every state except DONE. It goes 0 on the cycle the FSM enters DONE.
- done=1 only in DONE. error=1 only in ERR.
- start is honoured in IDLE, DONE and ERR. It moves to HDR0 and, in the same edge, clears index, words_loaded, the checksum accumulator, done and error, and sets cpu_hold=1.
- start is ignored in all other states.
- Reset values (rst_n low, asynchronous): state IDLE, cpu_hold=1, all other outputs 0, internal counters and accumulator 0.
- Reset mid-load aborts immediately and issues no further writes. Words already written stay in memory.
- On failure, words already written are not rolled back. cpu_hold stays 1 until a later successful load.

Test Plan:
- Good 2-word load:
  - Stimulus: start, then bytes 02 00, 20 50 00 00, 14 00 01 24, CSUM 43.
  - Response: writes (0x0, 0x00005020) and (0x4, 0x24010014), each mem_we one cycle. Then done=1, cpu_hold=0, words_loaded=2, error=0.
- Bad checksum: same stream with CSUM 44 -> both writes still occur; error=1, done=0, cpu_hold=1, rx_ready=0 afterwards.
- Empty image: bytes 00 00, CSUM 00 -> no mem_we, done=1, words_loaded=0, cpu_hold=0.
- Oversize: bytes FF FF with MAX_WORDS=16384 -> ERR after the 2nd header byte, no writes, rx_ready=0. A following start plus a valid 1-word stream loads successfully.
- Backpressure: rx_valid held high continuously across the 2-word stream -> rx_ready=0 on each WRITE cycle, the byte held during WRITE is consumed on the next cycle, and the final memory contents match scenario 1. Repeat with random rx_valid gaps -> identical result.
- Reset mid-payload: rst_n pulsed low after 2 payload bytes -> outputs return to reset values and no further writes occur. start plus a full valid stream then completes with done=1.
